// File: rtl/otter_pipe_pkg.sv
// Shared types and constants for the pipeline controller.
//   pipe_state_t : controller FSM states (START, RUN, MEM_WAIT)
//   PERF_W       : width of the performance counters
package otter_pipe_pkg;

   typedef enum logic [1:0] {
      START    = 2'd0,
      RUN      = 2'd1,
      MEM_WAIT = 2'd2
   } pipe_state_t;

   localparam int PERF_W = 32;

endpackage

// File: rtl/pipe_ctrl_if.sv
// Bundle of hazard inputs, pipeline-register controls, valid bits and
// performance counters exchanged between the datapath and pipe_ctrl.
//   master : datapath side (drives hazards/ready, receives controls)
//   slave  : controller side
interface pipe_ctrl_if;
   import otter_pipe_pkg::*;

   logic              load_use_haz;
   logic              control_haz;
   logic              imem_ready;
   logic              dmem_ready;
   logic              mem_access;
   logic              pc_we;
   logic              ifde_en;
   logic              deex_en;
   logic              exmem_en;
   logic              memwb_en;
   logic              ifde_flush;
   logic              deex_flush;
   logic              de_valid;
   logic              ex_valid;
   logic              mem_valid;
   logic              wb_valid;
   logic [PERF_W-1:0] stall_cnt;
   logic [PERF_W-1:0] flush_cnt;

   modport master (
      output load_use_haz, control_haz, imem_ready, dmem_ready, mem_access,
      input  pc_we, ifde_en, deex_en, exmem_en, memwb_en,
      input  ifde_flush, deex_flush,
      input  de_valid, ex_valid, mem_valid, wb_valid,
      input  stall_cnt, flush_cnt
   );

   modport slave (
      input  load_use_haz, control_haz, imem_ready, dmem_ready, mem_access,
      output pc_we, ifde_en, deex_en, exmem_en, memwb_en,
      output ifde_flush, deex_flush,
      output de_valid, ex_valid, mem_valid, wb_valid,
      output stall_cnt, flush_cnt
   );

endinterface

// File: rtl/pipe_event_ctr.sv
// Free-running event counter, wraps from all-ones to zero.
//   CLK   : clock
//   RST   : synchronous active-high clear
//   inc   : count one event this cycle
//   count : current count
module pipe_event_ctr
   import otter_pipe_pkg::*;
(
   input  logic              CLK,
   input  logic              RST,
   input  logic              inc,
   output logic [PERF_W-1:0] count
);

   logic [PERF_W-1:0] r_count;

   always_ff @(posedge CLK) begin
      if (RST) begin
         r_count <= '0;
      end else if (inc) begin
         r_count <= r_count + PERF_W'(1);
      end
   end

   assign count = r_count;

endmodule

// File: rtl/pipe_ctrl.sv
// Pipeline hazard/stall controller for a 5-stage pipeline.
//   CLK : clock
//   RST : synchronous active-high reset
//   bus : pipe_ctrl_if.slave -- hazard inputs, PC/pipeline-register
//         enables and flushes (combinational), stage valid bits and
//         stall/flush counters (registered)
module pipe_ctrl
   import otter_pipe_pkg::*;
(
   input  logic        CLK,
   input  logic        RST,
   pipe_ctrl_if.slave  bus
);

   pipe_state_t r_state, w_state_next;

   logic r_de_valid, r_ex_valid, r_mem_valid, r_wb_valid;
   logic w_de_valid_next, w_ex_valid_next, w_mem_valid_next, w_wb_valid_next;

   logic w_pc_we, w_ifde_en, w_deex_en, w_exmem_en, w_memwb_en;
   logic w_ifde_flush, w_deex_flush;
   logic w_stall, w_flush;
   logic w_ctl, w_lu, w_mem_wait;
   logic [PERF_W-1:0] w_stall_cnt, w_flush_cnt;

   // Hazards only count when the stages they refer to hold real instructions.
   assign w_ctl = bus.control_haz & r_ex_valid;
   assign w_lu  = bus.load_use_haz & r_ex_valid & r_de_valid;

   // Once waiting, only dmem_ready ends the wait; a MEM_WAIT cycle with
   // dmem_ready=1 falls through to the normal RUN decode below.
   assign w_mem_wait = (r_state == MEM_WAIT) ? ~bus.dmem_ready
                     : (bus.mem_access & r_mem_valid & ~bus.dmem_ready);

   always_ff @(posedge CLK) begin
      if (RST) begin
         r_state     <= START;
         r_de_valid  <= 1'b0;
         r_ex_valid  <= 1'b0;
         r_mem_valid <= 1'b0;
         r_wb_valid  <= 1'b0;
      end else begin
         r_state     <= w_state_next;
         r_de_valid  <= w_de_valid_next;
         r_ex_valid  <= w_ex_valid_next;
         r_mem_valid <= w_mem_valid_next;
         r_wb_valid  <= w_wb_valid_next;
      end
   end

   always_comb begin
      w_state_next     = r_state;
      w_pc_we          = 1'b0;
      w_ifde_en        = 1'b0;
      w_deex_en        = 1'b0;
      w_exmem_en       = 1'b0;
      w_memwb_en       = 1'b0;
      w_ifde_flush     = 1'b0;
      w_deex_flush     = 1'b0;
      w_stall          = 1'b0;
      w_flush          = 1'b0;
      w_de_valid_next  = r_de_valid;
      w_ex_valid_next  = r_ex_valid;
      w_mem_valid_next = r_mem_valid;
      w_wb_valid_next  = r_wb_valid;

      if (RST) begin
         // Front registers are held at bubbles while in reset.
         w_ifde_flush = 1'b1;
         w_deex_flush = 1'b1;
         w_state_next = START;
      end else if (r_state == START) begin
         w_state_next = RUN;
      end else begin
         w_state_next = RUN;
         if (w_mem_wait) begin
            // Freeze everything up to MEM; push a bubble into WB.
            w_state_next    = MEM_WAIT;
            w_memwb_en      = 1'b1;
            w_wb_valid_next = 1'b0;
            w_stall         = 1'b1;
         end else begin
            // Downstream stages always advance outside a memory wait.
            w_exmem_en       = 1'b1;
            w_memwb_en       = 1'b1;
            w_deex_en        = 1'b1;
            w_mem_valid_next = r_ex_valid;
            w_wb_valid_next  = r_mem_valid;
            if (w_ctl) begin
               // Wins over a simultaneous load-use: the DE instruction is
               // on the wrong path, so no stall is needed for it.
               w_pc_we         = 1'b1;
               w_ifde_en       = 1'b1;
               w_ifde_flush    = 1'b1;
               w_deex_flush    = 1'b1;
               w_de_valid_next = 1'b0;
               w_ex_valid_next = 1'b0;
               w_flush         = 1'b1;
            end else if (w_lu) begin
               // Hold PC and IF/DE; insert a bubble into EX.
               w_deex_flush    = 1'b1;
               w_ex_valid_next = 1'b0;
               w_stall         = 1'b1;
            end else if (!bus.imem_ready) begin
               w_ifde_en       = 1'b1;
               w_ifde_flush    = 1'b1;
               w_de_valid_next = 1'b0;
               w_ex_valid_next = r_de_valid;
               w_stall         = 1'b1;
            end else begin
               w_pc_we         = 1'b1;
               w_ifde_en       = 1'b1;
               w_de_valid_next = 1'b1;
               w_ex_valid_next = r_de_valid;
            end
         end
      end
   end

   pipe_event_ctr u_stall_ctr (
      .CLK   (CLK),
      .RST   (RST),
      .inc   (w_stall),
      .count (w_stall_cnt)
   );

   pipe_event_ctr u_flush_ctr (
      .CLK   (CLK),
      .RST   (RST),
      .inc   (w_flush),
      .count (w_flush_cnt)
   );

   assign bus.pc_we      = w_pc_we;
   assign bus.ifde_en    = w_ifde_en;
   assign bus.deex_en    = w_deex_en;
   assign bus.exmem_en   = w_exmem_en;
   assign bus.memwb_en   = w_memwb_en;
   assign bus.ifde_flush = w_ifde_flush;
   assign bus.deex_flush = w_deex_flush;
   assign bus.de_valid   = r_de_valid;
   assign bus.ex_valid   = r_ex_valid;
   assign bus.mem_valid  = r_mem_valid;
   assign bus.wb_valid   = r_wb_valid;
   assign bus.stall_cnt  = w_stall_cnt;
   assign bus.flush_cnt  = w_flush_cnt;

endmodule

// File: tb/tb_pipe_ctrl.sv
// Directed testbench for pipe_ctrl. Controls are packed as
// {pc_we, ifde_en, deex_en, exmem_en, memwb_en, ifde_flush, deex_flush},
// valid bits as {de, ex, mem, wb}.
module tb_pipe_ctrl;

   logic CLK;
   logic RST;
   int   n_checks;
   int   n_errors;

   pipe_ctrl_if bus ();

   pipe_ctrl dut (
      .CLK (CLK),
      .RST (RST),
      .bus (bus)
   );

   initial CLK = 1'b0;
   always #5 CLK = ~CLK;

   localparam logic [6:0] C_RESET = 7'b0000011;
   localparam logic [6:0] C_START = 7'b0000000;
   localparam logic [6:0] C_NORM  = 7'b1111100;
   localparam logic [6:0] C_LU    = 7'b0011101;
   localparam logic [6:0] C_CTL   = 7'b1111111;
   localparam logic [6:0] C_FETCH = 7'b0111110;
   localparam logic [6:0] C_WAIT  = 7'b0000100;

   function automatic logic [6:0] ctl_vec();
      return {bus.pc_we, bus.ifde_en, bus.deex_en, bus.exmem_en,
              bus.memwb_en, bus.ifde_flush, bus.deex_flush};
   endfunction

   function automatic logic [3:0] val_vec();
      return {bus.de_valid, bus.ex_valid, bus.mem_valid, bus.wb_valid};
   endfunction

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got=%h expected=%h", tag, got, exp);
      end else begin
         $display("ok   %s: %h", tag, got);
      end
   endtask

   task automatic drive(input logic lu, input logic ctl, input logic imem,
                        input logic dmem, input logic macc);
      bus.load_use_haz = lu;
      bus.control_haz  = ctl;
      bus.imem_ready   = imem;
      bus.dmem_ready   = dmem;
      bus.mem_access   = macc;
   endtask

   // Advance one clock; leave time 1 unit past the edge for sampling.
   task automatic tick();
      @(posedge CLK);
      #1;
   endtask

   initial begin
      n_checks = 0;
      n_errors = 0;
      RST = 1'b1;
      drive(1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
      tick();
      tick();

      // Reset behaviour
      check("rst_ctl", 32'(ctl_vec()), 32'(C_RESET));
      check("rst_valid", 32'(val_vec()), 32'h0);
      check("rst_stall", bus.stall_cnt, 32'h0);
      check("rst_flush", bus.flush_cnt, 32'h0);

      // Release: one START cycle, then fill the pipe
      RST = 1'b0;
      #1;
      check("start_ctl", 32'(ctl_vec()), 32'(C_START));
      tick();
      check("run0_valid", 32'(val_vec()), 32'h0);
      check("run0_ctl", 32'(ctl_vec()), 32'(C_NORM));
      tick();
      check("fill1_valid", 32'(val_vec()), 32'b1000);
      tick();
      tick();
      tick();
      check("fill4_valid", 32'(val_vec()), 32'b1111);

      // Load-use
      drive(1'b1, 1'b0, 1'b1, 1'b1, 1'b0);
      #1;
      check("lu_ctl", 32'(ctl_vec()), 32'(C_LU));
      tick();
      check("lu_valid", 32'(val_vec()), 32'b1011);
      check("lu_stall", bus.stall_cnt, 32'd1);
      drive(1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
      tick();
      tick();
      tick();
      check("lu_refill", 32'(val_vec()), 32'b1111);

      // Control hazard together with load-use: control wins
      drive(1'b1, 1'b1, 1'b1, 1'b1, 1'b0);
      #1;
      check("ctl_lu_ctl", 32'(ctl_vec()), 32'(C_CTL));
      tick();
      check("ctl_valid", 32'(val_vec()), 32'b0011);
      check("ctl_flush", bus.flush_cnt, 32'd1);
      check("ctl_stall", bus.stall_cnt, 32'd1);

      // control_haz with ex_valid=0 is ignored
      drive(1'b0, 1'b1, 1'b1, 1'b1, 1'b0);
      #1;
      check("ctl_unq_ctl", 32'(ctl_vec()), 32'(C_NORM));
      tick();
      check("ctl_unq_flush", bus.flush_cnt, 32'd1);
      check("ctl_unq_valid", 32'(val_vec()), 32'b1001);

      // Fetch wait
      drive(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
      #1;
      check("fetch_ctl", 32'(ctl_vec()), 32'(C_FETCH));
      tick();
      check("fetch_valid", 32'(val_vec()), 32'b0100);
      check("fetch_stall", bus.stall_cnt, 32'd2);
      drive(1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
      for (int i = 0; i < 4; i++) tick();
      check("fetch_refill", 32'(val_vec()), 32'b1111);

      // Memory wait for 3 cycles, with a control hazard that must lose
      drive(1'b0, 1'b1, 1'b1, 1'b0, 1'b1);
      for (int i = 0; i < 3; i++) begin
         #1;
         check($sformatf("mw%0d_ctl", i), 32'(ctl_vec()), 32'(C_WAIT));
         tick();
         check($sformatf("mw%0d_valid", i), 32'(val_vec()), 32'b1110);
      end
      check("mw_stall", bus.stall_cnt, 32'd5);
      check("mw_flush", bus.flush_cnt, 32'd1);
      drive(1'b0, 1'b0, 1'b1, 1'b1, 1'b1);
      #1;
      check("mw_exit_ctl", 32'(ctl_vec()), 32'(C_NORM));
      tick();
      check("mw_exit_valid", 32'(val_vec()), 32'b1111);
      check("mw_exit_stall", bus.stall_cnt, 32'd5);

      // Stall counter wrap
      drive(1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
      force dut.u_stall_ctr.r_count = 32'hFFFF_FFFF;
      release dut.u_stall_ctr.r_count;
      #1;
      check("wrap_pre", bus.stall_cnt, 32'hFFFF_FFFF);
      drive(1'b1, 1'b0, 1'b1, 1'b1, 1'b0);
      tick();
      check("wrap_post", bus.stall_cnt, 32'h0);

      // Reset in the middle of a memory wait
      drive(1'b0, 1'b0, 1'b1, 1'b0, 1'b1);
      tick();
      check("rmw_stall", bus.stall_cnt, 32'd1);
      RST = 1'b1;
      #1;
      check("rmw_rst_ctl", 32'(ctl_vec()), 32'(C_RESET));
      tick();
      check("rmw_valid", 32'(val_vec()), 32'h0);
      check("rmw_cnt", bus.stall_cnt, 32'h0);
      RST = 1'b0;
      drive(1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
      #1;
      check("rmw_start_ctl", 32'(ctl_vec()), 32'(C_START));
      tick();
      check("rmw_run_ctl", 32'(ctl_vec()), 32'(C_NORM));

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule

// File: doc/pipe_ctrl.md
PIPE_CTRL -- requirements
Module: pipe_ctrl

Interface
REQ-001 Port CLK, input, 1 bit: the single system clock; all state updates on its rising edge.
REQ-002 Port RST, input, 1 bit: reset, synchronous and active-high.
REQ-003 Port load_use_haz, input, 1 bit: load in EX whose rd is read by the instruction in DE.
REQ-004 Port control_haz, input, 1 bit: taken jal/jalr/branch resolved in EX (pc_source != 0).
REQ-005 Port imem_ready, input, 1 bit: instruction fetch data valid this cycle.
REQ-006 Port dmem_ready, input, 1 bit: data memory completes the access presented by MEM this cycle.
REQ-007 Port mem_access, input, 1 bit: instruction in MEM is a load or store.
REQ-008 Port pc_we, output, 1 bit: PC register write enable.
REQ-009 Ports ifde_en, deex_en, exmem_en, memwb_en, output, 1 bit each: pipeline register load enables.
REQ-010 Ports ifde_flush, deex_flush, output, 1 bit each: load a bubble (NOP, regWrite=0) into that register.
REQ-011 Ports de_valid, ex_valid, mem_valid, wb_valid, output, 1 bit each: stage holds a real instruction.
REQ-012 Ports stall_cnt, flush_cnt, output, 32 bits each: performance counters.

Function
REQ-013 Hazard qualification: control_haz SHALL be honoured only when ex_valid=1; load_use_haz only when ex_valid=1 and de_valid=1; mem_access only when mem_valid=1.
REQ-014 FSM states: START, RUN, MEM_WAIT.
REQ-015 START: entered on reset; holds for exactly one cycle; pc_we=0 and all enables=0; then goes to RUN.
REQ-016 RUN -> MEM_WAIT when a qualified mem_access occurs with dmem_ready=0; MEM_WAIT -> RUN in the cycle dmem_ready=1, and that cycle is evaluated as RUN.
REQ-017 MEM_WAIT: pc_we, ifde_en, deex_en and exmem_en SHALL be 0; memwb_en=1; wb_valid next=0, so a bubble enters WB.
REQ-018 Priority in RUN, high to low: memory wait, control hazard, load-use, fetch wait, normal advance.
REQ-019 Control hazard: pc_we=1, ifde_flush=1, deex_flush=1, all other enables=1; next de_valid=0 and ex_valid=0.
REQ-020 Load-use: pc_we=0, ifde_en=0, deex_flush=1, exmem_en=1, memwb_en=1; next ex_valid=0; DE instruction is retained.
REQ-021 Fetch wait (imem_ready=0, no higher event): pc_we=0, ifde_flush=1, downstream enables=1; next de_valid=0.
REQ-022 Normal advance: all enables=1, no flush; valid bits shift DE->EX->MEM->WB; de_valid next=1.
REQ-023 A flush SHALL override the enable of the same register; the register loads a bubble.
REQ-024 A control hazard and a load-use in the same cycle SHALL resolve as a control hazard only, and the load-use SHALL NOT count as a stall.
REQ-025 stall_cnt SHALL increment by 1 in each cycle spent in MEM_WAIT, load-use or fetch wait; flush_cnt SHALL increment by 1 in each control-hazard cycle; both wrap at 2^32-1 -> 0.
REQ-026 Control outputs are combinational from state and inputs (zero-cycle latency); valid bits and counters are registered.

Reset
REQ-027 While RST=1 at a rising edge: state=START; all valid bits=0; stall_cnt=0; flush_cnt=0.
REQ-028 While RST=1: pc_we=0, all enables=0, ifde_flush=1, deex_flush=1.
REQ-029 RST asserted mid-MEM_WAIT SHALL abandon the wait immediately, with no counter update in that cycle.

Structure
REQ-030 Package otter_pipe_pkg SHALL hold the state enum type pipe_state_t and the counter-width constant PERF_W=32.
REQ-031 Both counters SHALL be instances of one sub-module, pipe_event_ctr, with ports CLK, RST, inc, and count.

Verification
REQ-032 Reset release, steady imem_ready=1 -> one START cycle with pc_we=0; de_valid rises 1 cycle later; wb_valid=1 by cycle 5.
REQ-033 Qualified load_use_haz for 1 cycle -> pc_we=0, ifde_en=0, deex_flush=1; ex_valid=0 next cycle; stall_cnt=1.
REQ-034 control_haz and load_use_haz in the same cycle -> both flushes asserted, pc_we=1; flush_cnt=1, stall_cnt=0.
REQ-035 mem_access with dmem_ready=0 for 3 cycles -> MEM_WAIT for 3 cycles; wb_valid=0 during them; stall_cnt=3; advance on the 4th cycle.
REQ-036 stall_cnt preloaded to 0xFFFFFFFF plus one stall cycle -> 0x00000000; RST mid-MEM_WAIT -> state START and all valid bits 0 next cycle.
